// File: rtl/mem_port_arbiter.sv
// Oldest-first arbiter sharing one memory port among eight scheduler slots.
// Optional watchdog (timeout_err) is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       main_clk,
    input  logic       main_rst_n,
    input  logic [7:0] slot_alloc,
    input  logic [7:0] slot_free,
    input  logic       flush,
    input  logic [7:0] slot_req,
    output logic       mem_req,
    output logic [2:0] mem_slot,
    input  logic       mem_ack,
    input  logic       mem_done,
    output logic [7:0] done_onehot,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_reg;
    logic [7:0]  valid_reg;
    logic        mem_req_reg;
    logic [2:0]  mem_slot_reg;
    logic [7:0]  done_onehot_reg;
    logic        busy_reg;
    logic        flushed_reg;

    logic [63:0] older_flat;   // bit i*8+j: slot i is older than slot j
    logic [63:0] beats;        // bit i*8+j: requester j is older than requester i
    logic [7:0]  req_v;
    logic [7:0]  winner_oh;
    logic [2:0]  winner_idx;
    logic        grant;

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n)
            valid_reg <= '0;
        else if (flush)
            valid_reg <= '0;
        else
            valid_reg <= (valid_reg & ~slot_free) | slot_alloc;
    end

    // Only the upper triangle is stored; the lower triangle is its complement.
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
        for (genvar gj = 0; gj < 8; gj++) begin : g_col
            if (gi < gj) begin : g_upper
                logic age_reg;
                // A newly allocated slot is younger than everything else; when both
                // are allocated together the lower index (gi) stays older.
                always_ff @(posedge main_clk or negedge main_rst_n) begin
                    if (!main_rst_n)
                        age_reg <= 1'b1;
                    else if (!flush && slot_alloc[gj])
                        age_reg <= 1'b1;
                    else if (!flush && slot_alloc[gi])
                        age_reg <= 1'b0;
                end
                assign older_flat[gi*8+gj] = age_reg;
                assign older_flat[gj*8+gi] = ~age_reg;
            end else if (gi == gj) begin : g_diag
                assign older_flat[gi*8+gj] = 1'b0;
            end
            assign beats[gi*8+gj] = req_v[gj] & older_flat[gj*8+gi];
        end
        assign winner_oh[gi] = req_v[gi] & ~|beats[gi*8 +: 8];
    end

    assign req_v = valid_reg & slot_req;
    // A flush in the arbitration cycle invalidates every candidate, so no grant.
    assign grant = (|winner_oh) & ~flush;

    always_comb begin
        winner_idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (winner_oh[i]) winner_idx = 3'(i);
    end

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            state_reg       <= S_IDLE;
            mem_req_reg     <= 1'b0;
            mem_slot_reg    <= 3'd0;
            done_onehot_reg <= '0;
            busy_reg        <= 1'b0;
            flushed_reg     <= 1'b0;
        end else begin
            done_onehot_reg <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (grant) begin
                        state_reg    <= S_REQ;
                        mem_req_reg  <= 1'b1;
                        mem_slot_reg <= winner_idx;
                        busy_reg     <= 1'b1;
                        flushed_reg  <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        state_reg   <= S_WAIT;
                        mem_req_reg <= 1'b0;
                        flushed_reg <= flushed_reg | flush;
                    end else if (flush) begin
                        state_reg   <= S_IDLE;
                        mem_req_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                        if (!flushed_reg && !flush)
                            done_onehot_reg <= 8'b1 << mem_slot_reg;
                    end else if (flush) begin
                        flushed_reg <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign mem_req     = mem_req_reg;
    assign mem_slot    = mem_slot_reg;
    assign done_onehot = done_onehot_reg;
    assign busy        = busy_reg;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt_reg;
    logic             timeout_err_reg;

    always_ff @(posedge main_clk or negedge main_rst_n) begin
        if (!main_rst_n) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE)
                wd_cnt_reg <= '0;
            else if (wd_cnt_reg != CNT_W'(TIMEOUT_CYCLES))
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            if (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES))
                timeout_err_reg <= 1'b1;
        end
    end
    assign timeout_err = timeout_err_reg;
`else
    assign timeout_err = 1'b0;
`endif

    a_timeout_cfg: assert property (@(posedge main_clk) TIMEOUT_CYCLES > 0);
    a_alloc_valid: assert property (@(posedge main_clk) disable iff (!main_rst_n)
        !flush |-> ((slot_alloc & valid_reg) == 8'h00));
    a_free_busy: assert property (@(posedge main_clk) disable iff (!main_rst_n)
        (busy_reg && !flush) |-> !slot_free[mem_slot_reg]);
    a_done_wait: assert property (@(posedge main_clk) disable iff (!main_rst_n)
        mem_done |-> (state_reg == S_WAIT));
    a_alloc_free: assert property (@(posedge main_clk) disable iff (!main_rst_n)
        (slot_alloc & slot_free) == 8'h00);

endmodule
